// File: rtl/demoman_pkg.sv
// Shared constants for the game's input plumbing: controller channel map and
// debounce timing, plus the raw-pin-to-pressed polarity helper.
package demoman_pkg;

   localparam int unsigned CH_P1_LEFT          = 0;
   localparam int unsigned CH_P1_RIGHT         = 1;
   localparam int unsigned CH_P1_ATTACK        = 2;
   localparam int unsigned CH_P2_LEFT          = 3;
   localparam int unsigned CH_P2_RIGHT         = 4;
   localparam int unsigned CH_P2_ATTACK        = 5;
   localparam int unsigned NUM_INPUT_CH        = 6;

   localparam int unsigned DEBOUNCE_10MS_50MHZ = 500000;

   function automatic logic to_pressed(input logic pin, input bit active_low);
      return active_low ? ~pin : pin;
   endfunction

endpackage

// File: rtl/debounce_channel.sv
// One conditioned input: 2-FF synchroniser, counter debounce and one-cycle
// rise/fall pulses aligned with the first cycle of the new debounced level.
module debounce_channel
   import demoman_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS_50MHZ,
   parameter bit          ACTIVE_LOW      = 1'b1,
   parameter int unsigned CNT_W           = 20
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_raw,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);

   localparam logic             RELEASED = ACTIVE_LOW ? 1'b1 : 1'b0;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             r_s1;
   logic             r_s2;
   logic             r_level;
   logic             r_rise;
   logic             r_fall;
   logic [CNT_W-1:0] r_cnt;
   logic             w_s;
   logic             w_expired;

   assign w_s       = to_pressed(r_s2, ACTIVE_LOW);
   assign w_expired = (r_cnt == CNT_LAST);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         // Syncs load the released pin value so level stays 0 after reset.
         r_s1    <= RELEASED;
         r_s2    <= RELEASED;
         r_level <= 1'b0;
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_s1   <= i_raw;
         r_s2   <= r_s1;
         r_rise <= 1'b0;
         r_fall <= 1'b0;
         if (w_s == r_level) begin
            r_cnt <= '0;
         end else if (w_expired) begin
            r_level <= w_s;
            r_cnt   <= '0;
            r_rise  <= w_s;
            r_fall  <= ~w_s;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign o_level = r_level;
   assign o_rise  = r_rise;
   assign o_fall  = r_fall;

endmodule

// File: rtl/input_conditioner.sv
// Conditions the controller pins for the ~60 Hz game logic: per-channel debounce
// plus per-frame snapshots that never lose a tap shorter than one frame.
module input_conditioner
   import demoman_pkg::*;
#(
   parameter int unsigned NUM_CH          = NUM_INPUT_CH,
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS_50MHZ,
   parameter bit          ACTIVE_LOW      = 1'b1,
   parameter int unsigned CNT_W           = 20
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NUM_CH-1:0] raw_in,
   input  logic              frame_tick,
   output logic [NUM_CH-1:0] level,
   output logic [NUM_CH-1:0] rise,
   output logic [NUM_CH-1:0] fall,
   output logic [NUM_CH-1:0] frame_held,
   output logic [NUM_CH-1:0] frame_pressed
);

   logic [NUM_CH-1:0] w_level;
   logic [NUM_CH-1:0] w_rise;
   logic [NUM_CH-1:0] w_fall;
   logic [NUM_CH-1:0] r_sticky;
   logic [NUM_CH-1:0] r_held;
   logic [NUM_CH-1:0] r_pressed;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      debounce_channel #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .ACTIVE_LOW      (ACTIVE_LOW),
         .CNT_W           (CNT_W)
      ) u_ch (
         .i_clk   (clk),
         .i_rst_n (rst_n),
         .i_raw   (raw_in[g]),
         .o_level (w_level[g]),
         .o_rise  (w_rise[g]),
         .o_fall  (w_fall[g])
      );
   end

   // A rise on the tick cycle belongs to the frame being closed, not the next one.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_sticky  <= '0;
         r_held    <= '0;
         r_pressed <= '0;
      end else if (frame_tick) begin
         r_held    <= w_level | r_sticky;
         r_pressed <= w_rise | r_sticky;
         r_sticky  <= '0;
      end else begin
         r_sticky  <= r_sticky | w_rise;
      end
   end

   assign level         = w_level;
   assign rise          = w_rise;
   assign fall          = w_fall;
   assign frame_held    = r_held;
   assign frame_pressed = r_pressed;

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner (DEBOUNCE_CYCLES=4, ACTIVE_LOW=1)
// against a window-based reference model of the debounce and frame rules.
module tb_input_conditioner;

   localparam int unsigned NCH = 6;
   localparam int unsigned D   = 4;
   localparam logic [NCH-1:0] ALL_CH  = '1;
   localparam logic [D-1:0]   WIN_ONE = '1;

   logic           clk = 1'b0;
   logic           rst_n = 1'b1;
   logic [NCH-1:0] raw_in = '1;
   logic           frame_tick = 1'b0;
   logic [NCH-1:0] level, rise, fall, frame_held, frame_pressed;

   int n_vec = 0;
   int n_err = 0;

   input_conditioner #(
      .NUM_CH          (NCH),
      .DEBOUNCE_CYCLES (D),
      .ACTIVE_LOW      (1'b1),
      .CNT_W           (3)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .raw_in        (raw_in),
      .frame_tick    (frame_tick),
      .level         (level),
      .rise          (rise),
      .fall          (fall),
      .frame_held    (frame_held),
      .frame_pressed (frame_pressed)
   );

   always #5 clk = ~clk;

   // Reference model: level flips once the last D synchronised samples all
   // disagree with it; pins reach the debouncer two edges after being sampled.
   logic [NCH-1:0] m_level, m_rise, m_fall, m_held, m_pressed, m_sticky;
   logic [NCH-1:0] h0, h1;
   logic [D-1:0]   win [NCH];
   logic [5*NCH-1:0] obs, mobs;

   assign obs  = {level, rise, fall, frame_held, frame_pressed};
   assign mobs = {m_level, m_rise, m_fall, m_held, m_pressed};

   always @(posedge clk) begin
      logic [NCH-1:0] s;
      if (!rst_n) begin
         m_level = '0; m_rise = '0; m_fall = '0;
         m_held = '0; m_pressed = '0; m_sticky = '0;
         h0 = '1; h1 = '1;
         for (int ch = 0; ch < NCH; ch++) win[ch] = '0;
      end else begin
         if (frame_tick) begin
            m_held    = m_level | m_sticky;
            m_pressed = m_rise | m_sticky;
            m_sticky  = '0;
         end else begin
            m_sticky  = m_sticky | m_rise;
         end
         s = ~h1;
         for (int ch = 0; ch < NCH; ch++) begin
            win[ch] = {win[ch][D-2:0], s[ch]};
            m_rise[ch] = 1'b0;
            m_fall[ch] = 1'b0;
            if (m_level[ch] ? (win[ch] == '0) : (win[ch] == WIN_ONE)) begin
               m_level[ch] = ~m_level[ch];
               m_rise[ch]  = m_level[ch];
               m_fall[ch]  = ~m_level[ch];
            end
         end
         h1 = h0;
         h0 = raw_in;
      end
   end

   task automatic settle();
      @(negedge clk);
      rst_n = 1'b1; raw_in = ALL_CH; frame_tick = 1'b0;
      repeat (10) @(negedge clk);
   endtask

   task automatic test_reset();
      logic [NCH-1:0] exp_l, exp_r;
      @(negedge clk);
      rst_n = 1'b0; raw_in = '0; frame_tick = 1'b0;
      repeat (3) begin
         @(negedge clk);
         n_vec++;
         if (obs !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h expected 0", obs);
         end
      end
      rst_n = 1'b1;
      for (int e = 1; e <= 7; e++) begin
         @(negedge clk);
         exp_l = (e >= 6) ? ALL_CH : '0;
         exp_r = (e == 6) ? ALL_CH : '0;
         n_vec++;
         if (level !== exp_l || rise !== exp_r) begin
            n_err++;
            $display("FAIL reset_release edge %0d: level=%b rise=%b expected level=%b rise=%b",
                     e, level, rise, exp_l, exp_r);
         end
         n_vec++;
         if (obs !== mobs) begin
            n_err++;
            $display("FAIL reset_model edge %0d: got %h expected %h", e, obs, mobs);
         end
      end
   endtask

   task automatic test_single_press();
      settle();
      raw_in[0] = 1'b0;
      for (int e = 1; e <= 8; e++) begin
         @(negedge clk);
         n_vec++;
         if (level[0] !== (e >= 6) || rise[0] !== (e == 6) || level[5:1] !== '0) begin
            n_err++;
            $display("FAIL single_press edge %0d: level=%b rise=%b expected level0=%0d rise0=%0d",
                     e, level, rise, (e >= 6), (e == 6));
         end
         n_vec++;
         if (obs !== mobs) begin
            n_err++;
            $display("FAIL single_model edge %0d: got %h expected %h", e, obs, mobs);
         end
      end
   endtask

   task automatic test_bounce();
      settle();
      for (int i = 0; i < 10; i++) begin
         raw_in[1] = (i % 2 == 1);
         repeat (2) begin
            @(negedge clk);
            n_vec++;
            if (level[1] !== 1'b0 || obs !== mobs) begin
               n_err++;
               $display("FAIL bounce_toggle: level1=%b got %h expected level1=0 model %h",
                        level[1], obs, mobs);
            end
         end
      end
      raw_in[1] = 1'b0;
      for (int e = 1; e <= 7; e++) begin
         @(negedge clk);
         n_vec++;
         if (level[1] !== (e >= 6) || obs !== mobs) begin
            n_err++;
            $display("FAIL bounce_settle edge %0d: level1=%b expected %0d (obs %h model %h)",
                     e, level[1], (e >= 6), obs, mobs);
         end
      end
   endtask

   task automatic test_frame_press();
      settle();
      for (int c = 0; c <= 200; c++) begin
         frame_tick = (c == 0 || c == 100 || c == 200);
         raw_in[2]  = !(c >= 20 && c < 30);
         @(negedge clk);
         n_vec++;
         if (obs !== mobs) begin
            n_err++;
            $display("FAIL frame_model cyc %0d: got %h expected %h", c, obs, mobs);
         end
         if (c == 100 || c == 200) begin
            n_vec++;
            if (frame_held[2] !== (c == 100) || frame_pressed[2] !== (c == 100)) begin
               n_err++;
               $display("FAIL frame_snapshot cyc %0d: held2=%b pressed2=%b expected %0d",
                        c, frame_held[2], frame_pressed[2], (c == 100));
            end
         end
      end
      frame_tick = 1'b0;
   endtask

   task automatic test_tick_coincident();
      settle();
      for (int c = 0; c <= 50; c++) begin
         raw_in[3]  = 1'b0;
         frame_tick = (c == 6 || c == 50);
         @(negedge clk);
         n_vec++;
         if (obs !== mobs) begin
            n_err++;
            $display("FAIL coinc_model cyc %0d: got %h expected %h", c, obs, mobs);
         end
         if (c == 5 || c == 6 || c == 50) begin
            n_vec++;
            if ((c == 5 && rise[3] !== 1'b1) ||
                (c == 6 && (frame_pressed[3] !== 1'b1 || frame_held[3] !== 1'b1)) ||
                (c == 50 && (frame_pressed[3] !== 1'b0 || frame_held[3] !== 1'b1))) begin
               n_err++;
               $display("FAIL coinc_tick cyc %0d: rise3=%b held3=%b pressed3=%b",
                        c, rise[3], frame_held[3], frame_pressed[3]);
            end
         end
      end
      frame_tick = 1'b0;
   endtask

   task automatic test_reset_midcount();
      settle();
      raw_in[4] = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      n_vec++;
      if (obs !== '0) begin
         n_err++;
         $display("FAIL midcount_reset: got %h expected 0", obs);
      end
      rst_n = 1'b1;
      for (int e = 1; e <= 7; e++) begin
         @(negedge clk);
         n_vec++;
         if (level[4] !== (e >= 6) || obs !== mobs) begin
            n_err++;
            $display("FAIL midcount_restart edge %0d: level4=%b expected %0d (obs %h model %h)",
                     e, level[4], (e >= 6), obs, mobs);
         end
      end
   endtask

   task automatic test_random();
      int next_tick;
      settle();
      next_tick = 20;
      for (int c = 0; c < 3000; c++) begin
         for (int ch = 0; ch < NCH; ch++)
            if ($urandom_range(0, 5) == 0) raw_in[ch] = ~raw_in[ch];
         frame_tick = (c == next_tick);
         if (frame_tick) next_tick = c + $urandom_range(3, 60);
         rst_n = ($urandom_range(0, 499) != 0);
         @(negedge clk);
         n_vec++;
         if (obs !== mobs) begin
            n_err++;
            $display("FAIL random_model cyc %0d: got %h expected %h", c, obs, mobs);
         end
      end
      rst_n = 1'b1;
      frame_tick = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish, %0d vectors applied", n_vec);
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_single_press();
      test_bounce();
      test_frame_press();
      test_tick_coincident();
      test_reset_midcount();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
